// File: rtl/gpr_pkg.sv
// rtl/gpr_pkg.sv - shared types and constants for the GPR file and its debug port
package gpr_pkg;

  typedef enum logic [1:0] {
    OK         = 2'd0,
    NOT_HALTED = 2'd1,
    BAD_ADDR   = 2'd2,
    CONFLICT   = 2'd3
  } dbg_err_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } dbg_state_e;

  localparam logic [15:0] DBG_REGNO_GPR_BASE = 16'h1000;

endpackage

// File: rtl/gpr_dbg_fsm.sv
// rtl/gpr_dbg_fsm.sv - debug request/response handshake, regno decode and status generation
module gpr_dbg_fsm
  import gpr_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          NUM_REGS = 32,
  parameter logic [15:0] DBG_BASE = DBG_REGNO_GPR_BASE,
  localparam int         AW       = $clog2(NUM_REGS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            halted_i,
  input  logic            rd_we_i,
  input  logic [AW-1:0]   rd_addr_i,
  input  logic            dbg_req_i,
  output logic            dbg_ready_o,
  input  logic            dbg_we_i,
  input  logic [15:0]     dbg_addr_i,
  input  logic [XLEN-1:0] dbg_wdata_i,
  output logic            dbg_rvalid_o,
  input  logic            dbg_rready_i,
  output logic [XLEN-1:0] dbg_rdata_o,
  output dbg_err_e        dbg_err_o,
  output logic [AW-1:0]   gpr_idx_o,
  input  logic [XLEN-1:0] gpr_rdata_i,
  output logic            gpr_we_o,
  output logic [XLEN-1:0] gpr_wdata_o
);

  dbg_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic [15:0]     addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            ready_q, ready_d;
  logic            rvalid_q, rvalid_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  dbg_err_e        err_q, err_d;
  logic            in_range;
  dbg_err_e        status;

  always_comb begin
    gpr_idx_o = AW'(addr_q - DBG_BASE);
    in_range  = (addr_q >= DBG_BASE) &&
                ({1'b0, addr_q} < ({1'b0, DBG_BASE} + 17'(NUM_REGS)));
    // The core write always wins a same-index collision; the debug write is dropped.
    if (!halted_i)
      status = NOT_HALTED;
    else if (!in_range)
      status = BAD_ADDR;
    else if (we_q && rd_we_i && (rd_addr_i == gpr_idx_o) && (gpr_idx_o != '0))
      status = CONFLICT;
    else
      status = OK;
    gpr_we_o    = (state_q == EXEC) && we_q && (status == OK) && (gpr_idx_o != '0);
    gpr_wdata_o = wdata_q;
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ready_d  = ready_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (dbg_req_i) begin
          we_d    = dbg_we_i;
          addr_d  = dbg_addr_i;
          wdata_d = dbg_wdata_i;
          ready_d = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rdata_d  = (!we_q && status == OK) ? gpr_rdata_i : '0;
        err_d    = status;
        rvalid_d = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        if (dbg_rready_i) begin
          rvalid_d = 1'b0;
          rdata_d  = '0;
          err_d    = OK;
          ready_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        ready_d  = 1'b1;
        rvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= OK;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign dbg_ready_o  = ready_q;
  assign dbg_rvalid_o = rvalid_q;
  assign dbg_rdata_o  = rdata_q;
  assign dbg_err_o    = err_q;

endmodule

// File: rtl/gpr_file_dbg.sv
// rtl/gpr_file_dbg.sv - GPR array with two combinational read ports, core write port and debug port
module gpr_file_dbg
  import gpr_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          NUM_REGS = 32,
  parameter int          BYPASS   = 1,
  parameter logic [15:0] DBG_BASE = DBG_REGNO_GPR_BASE,
  localparam int         AW       = $clog2(NUM_REGS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic [AW-1:0]   rd_addr_i,
  input  logic [XLEN-1:0] rd_data_i,
  input  logic            rd_we_i,
  input  logic            halted_i,
  input  logic            dbg_req_i,
  output logic            dbg_ready_o,
  input  logic            dbg_we_i,
  input  logic [15:0]     dbg_addr_i,
  input  logic [XLEN-1:0] dbg_wdata_i,
  output logic            dbg_rvalid_o,
  input  logic            dbg_rready_i,
  output logic [XLEN-1:0] dbg_rdata_o,
  output dbg_err_e        dbg_err_o
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];
  logic [AW-1:0]   gpr_idx;
  logic            gpr_we;
  logic [XLEN-1:0] gpr_wdata;
  logic            core_wr;

  gpr_dbg_fsm #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS),
    .DBG_BASE (DBG_BASE)
  ) u_dbg_fsm (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .halted_i     (halted_i),
    .rd_we_i      (rd_we_i),
    .rd_addr_i    (rd_addr_i),
    .dbg_req_i    (dbg_req_i),
    .dbg_ready_o  (dbg_ready_o),
    .dbg_we_i     (dbg_we_i),
    .dbg_addr_i   (dbg_addr_i),
    .dbg_wdata_i  (dbg_wdata_i),
    .dbg_rvalid_o (dbg_rvalid_o),
    .dbg_rready_i (dbg_rready_i),
    .dbg_rdata_o  (dbg_rdata_o),
    .dbg_err_o    (dbg_err_o),
    .gpr_idx_o    (gpr_idx),
    .gpr_rdata_i  (regs_q[gpr_idx]),
    .gpr_we_o     (gpr_we),
    .gpr_wdata_o  (gpr_wdata)
  );

  assign core_wr = rd_we_i && (rd_addr_i != '0);

  // Debug and core writes never target the same index: the FSM reports CONFLICT instead.
  always_comb begin
    regs_d = regs_q;
    if (core_wr)
      regs_d[rd_addr_i] = rd_data_i;
    if (gpr_we)
      regs_d[gpr_idx] = gpr_wdata;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      regs_q <= '{default: '0};
    else
      regs_q <= regs_d;
  end

  always_comb begin
    rs1_data_o = regs_q[rs1_addr_i];
    rs2_data_o = regs_q[rs2_addr_i];
    if (BYPASS != 0 && core_wr && rs1_addr_i == rd_addr_i)
      rs1_data_o = rd_data_i;
    if (BYPASS != 0 && core_wr && rs2_addr_i == rd_addr_i)
      rs2_data_o = rd_data_i;
  end

endmodule

// File: tb/tb_gpr_file_dbg.sv
// tb/tb_gpr_file_dbg.sv - directed self-checking bench for gpr_file_dbg
module tb_gpr_file_dbg;
  import gpr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data, rd_data;
  logic        rd_we, halted;
  logic        dbg_req, dbg_ready, dbg_we, dbg_rvalid, dbg_rready;
  logic [15:0] dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  dbg_err_e    dbg_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] t_rdata;
  logic [1:0]  t_err;
  int          t_lat;

  always #5 clk = ~clk;

  gpr_file_dbg dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .rs1_addr_i   (rs1_addr),
    .rs2_addr_i   (rs2_addr),
    .rs1_data_o   (rs1_data),
    .rs2_data_o   (rs2_data),
    .rd_addr_i    (rd_addr),
    .rd_data_i    (rd_data),
    .rd_we_i      (rd_we),
    .halted_i     (halted),
    .dbg_req_i    (dbg_req),
    .dbg_ready_o  (dbg_ready),
    .dbg_we_i     (dbg_we),
    .dbg_addr_i   (dbg_addr),
    .dbg_wdata_i  (dbg_wdata),
    .dbg_rvalid_o (dbg_rvalid),
    .dbg_rready_i (dbg_rready),
    .dbg_rdata_o  (dbg_rdata),
    .dbg_err_o    (dbg_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_wr(input logic [4:0] a, input logic [31:0] d);
    rd_we = 1'b1; rd_addr = a; rd_data = d;
    tick();
    rd_we = 1'b0;
  endtask

  task automatic dbg_txn(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                         input logic cw_en, input logic [4:0] cw_addr, input logic [31:0] cw_data,
                         output logic [31:0] rdata, output logic [1:0] err, output int lat);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    tick();
    dbg_req = 1'b0;
    rd_we = cw_en; rd_addr = cw_addr; rd_data = cw_data;
    lat = 0;
    while (!dbg_rvalid && lat < 8) begin
      tick();
      lat++;
      rd_we = 1'b0;
    end
    rd_we = 1'b0;
    rdata = dbg_rdata;
    err   = dbg_err;
    dbg_rready = 1'b1;
    tick();
    dbg_rready = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; rs1_addr = '0; rs2_addr = '0; rd_addr = '0; rd_data = '0; rd_we = 1'b0;
    halted = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_rready = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    rs1_addr = 5'd5;
    #1;
    check_eq("rst_ready",  32'(dbg_ready), 32'd1);
    check_eq("rst_rvalid", 32'(dbg_rvalid), 32'd0);
    check_eq("rst_rdata",  dbg_rdata, 32'd0);
    check_eq("rst_err",    32'(dbg_err), 32'd0);
    check_eq("rst_x5",     rs1_data, 32'd0);

    rd_we = 1'b1; rd_addr = 5'd5; rd_data = 32'h6; #1;
    check_eq("bypass_x5", rs1_data, 32'h6);
    tick(); rd_we = 1'b0; #1;
    check_eq("stored_x5", rs1_data, 32'h6);

    rs1_addr = 5'd0; rd_we = 1'b1; rd_addr = 5'd0; rd_data = 32'hDEADBEEF; #1;
    check_eq("x0_nobypass", rs1_data, 32'h0);
    tick(); rd_we = 1'b0; #1;
    check_eq("x0_core_wr", rs1_data, 32'h0);

    halted = 1'b1;
    dbg_txn(1'b1, 16'h1000, 32'h1234, 1'b0, 5'd0, 32'h0, t_rdata, t_err, t_lat);
    check_eq("x0_dbg_err", 32'(t_err), 32'(OK));
    #1;
    check_eq("x0_dbg_val", rs1_data, 32'h0);

    core_wr(5'd4, 32'h9);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h1004;
    tick();
    dbg_req = 1'b0;
    check_eq("rd_exec_ready",  32'(dbg_ready), 32'd0);
    check_eq("rd_exec_rvalid", 32'(dbg_rvalid), 32'd0);
    tick();
    check_eq("rd_rvalid", 32'(dbg_rvalid), 32'd1);
    check_eq("rd_rdata",  dbg_rdata, 32'h9);
    check_eq("rd_err",    32'(dbg_err), 32'(OK));
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_rvalid", 32'(dbg_rvalid), 32'd1);
      check_eq("hold_rdata",  dbg_rdata, 32'h9);
      check_eq("hold_ready",  32'(dbg_ready), 32'd0);
    end
    dbg_rready = 1'b1; tick(); dbg_rready = 1'b0;
    check_eq("rd_done_rvalid", 32'(dbg_rvalid), 32'd0);
    check_eq("rd_done_ready",  32'(dbg_ready), 32'd1);

    core_wr(5'd8, 32'h80);
    halted = 1'b0;
    dbg_txn(1'b1, 16'h1008, 32'hAB, 1'b0, 5'd0, 32'h0, t_rdata, t_err, t_lat);
    check_eq("nh_err",   32'(t_err), 32'(NOT_HALTED));
    check_eq("nh_rdata", t_rdata, 32'h0);
    rs1_addr = 5'd8; #1;
    check_eq("nh_x8", rs1_data, 32'h80);

    halted = 1'b1;
    dbg_txn(1'b0, 16'h1020, 32'h0, 1'b0, 5'd0, 32'h0, t_rdata, t_err, t_lat);
    check_eq("bad_hi_err", 32'(t_err), 32'(BAD_ADDR));
    dbg_txn(1'b0, 16'h0FFF, 32'h0, 1'b0, 5'd0, 32'h0, t_rdata, t_err, t_lat);
    check_eq("bad_lo_err", 32'(t_err), 32'(BAD_ADDR));
    core_wr(5'd31, 32'hA5A5_0031);
    dbg_txn(1'b0, 16'h101F, 32'h0, 1'b0, 5'd0, 32'h0, t_rdata, t_err, t_lat);
    check_eq("top_err",   32'(t_err), 32'(OK));
    check_eq("top_rdata", t_rdata, 32'hA5A5_0031);
    check_eq("top_lat",   32'(t_lat), 32'd1);

    dbg_txn(1'b1, 16'h1009, 32'h11, 1'b1, 5'd9, 32'h22, t_rdata, t_err, t_lat);
    check_eq("cf_err",   32'(t_err), 32'(CONFLICT));
    check_eq("cf_rdata", t_rdata, 32'h0);
    rs1_addr = 5'd9; #1;
    check_eq("cf_x9", rs1_data, 32'h22);

    dbg_txn(1'b1, 16'h100A, 32'h77, 1'b1, 5'd3, 32'h33, t_rdata, t_err, t_lat);
    check_eq("wr_err", 32'(t_err), 32'(OK));
    rs2_addr = 5'd10; rs1_addr = 5'd3; #1;
    check_eq("wr_x10", rs2_data, 32'h77);
    check_eq("wr_x3",  rs1_data, 32'h33);
    dbg_txn(1'b0, 16'h100A, 32'h0, 1'b0, 5'd0, 32'h0, t_rdata, t_err, t_lat);
    check_eq("rb_x10", t_rdata, 32'h77);

    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h100D; dbg_wdata = 32'h55;
    tick();
    dbg_req = 1'b0; rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check_eq("rstx_rvalid", 32'(dbg_rvalid), 32'd0);
    check_eq("rstx_ready",  32'(dbg_ready), 32'd1);
    tick();
    rs1_addr = 5'd13; rs2_addr = 5'd5; #1;
    check_eq("rstx_rvalid2", 32'(dbg_rvalid), 32'd0);
    check_eq("rstx_x13",     rs1_data, 32'h0);
    check_eq("rstx_x5",      rs2_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
